// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - fetch_state_t : refill controller state encoding (IDLE / REFILL)
//   - NOP_INSTR     : instruction returned to IF/ID whenever the lookup misses
//   - width helpers : offset / index / tag widths derived from LINES and WORDS
// -----------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  // Word-offset bits inside a line.
  function automatic int off_bits(input int words);
    return $clog2(words);
  endfunction

  // Line-index bits.
  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Tag bits: whatever is left of the 32-bit byte address above the index.
  function automatic int tag_bits(input int lines, input int words);
    return 32 - 2 - $clog2(lines) - $clog2(words);
  endfunction

  localparam int DEF_OFF_W = off_bits(DEF_WORDS);
  localparam int DEF_IDX_W = idx_bits(DEF_LINES);
  localparam int DEF_TAG_W = tag_bits(DEF_LINES, DEF_WORDS);

endpackage

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Refill sequencer for the instruction cache. Owns the IDLE/REFILL state, the
// beat counter, the pending-invalidate flag and the memory request interface.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          a lookup missed in IDLE: begin refilling the line holding pc
//   pc             fetch byte address (line base captured on start)
//   inv            invalidate-all pulse
//   mem_valid      memory beat valid
//   state          current controller state
//   beat           word slot being filled by the current beat
//   beat_we        write mem_rdata into data[line][beat] this cycle
//   fill_done      final beat accepted this cycle (write the tag)
//   fill_keep      final beat accepted and no invalidate seen: mark line valid
//   inv_all        clear every valid bit at the next edge
//   inv_pending    an invalidate arrived during the current refill
//   line_base      byte address of the line being refilled
//   mem_req        refill request (high for the whole refill)
//   mem_addr       address of the beat currently requested
// -----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int WORDS = DEF_WORDS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                pc,
  input  logic                       inv,
  input  logic                       mem_valid,
  output fetch_state_t               state,
  output logic [$clog2(WORDS)-1:0]   beat,
  output logic                       beat_we,
  output logic                       fill_done,
  output logic                       fill_keep,
  output logic                       inv_all,
  output logic                       inv_pending,
  output logic [31:0]                line_base,
  output logic                       mem_req,
  output logic [31:0]                mem_addr
);

  localparam int OB = $clog2(WORDS);
  localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);
  localparam logic [OB-1:0] ONE_BEAT  = OB'(1);
  localparam logic [OB-1:0] ZERO_BEAT = OB'(0);

  fetch_state_t  state_r, state_nxt_s;
  logic [OB-1:0] beat_r, beat_nxt_s;
  logic          inv_pend_r, inv_pend_nxt_s;
  logic [31:0]   base_r, base_nxt_s;
  logic [31:0]   addr_r, addr_nxt_s;
  logic          beat_we_s, fill_done_s;
  logic          unused_pc_low_s;

  // Offset and byte bits of pc are replaced by zeros when the base is captured.
  assign unused_pc_low_s = ^pc[OB+1:0];

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      beat_r     <= ZERO_BEAT;
      inv_pend_r <= 1'b0;
      base_r     <= 32'h0000_0000;
      addr_r     <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      beat_r     <= beat_nxt_s;
      inv_pend_r <= inv_pend_nxt_s;
      base_r     <= base_nxt_s;
      addr_r     <= addr_nxt_s;
    end
  end

  // Next-state, beat sequencing and invalidate bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    beat_nxt_s     = beat_r;
    inv_pend_nxt_s = inv_pend_r;
    base_nxt_s     = base_r;
    addr_nxt_s     = addr_r;
    beat_we_s      = 1'b0;
    fill_done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s    = ST_REFILL;
          base_nxt_s     = {pc[31:OB+2], {(OB+2){1'b0}}};
          addr_nxt_s     = {pc[31:OB+2], {(OB+2){1'b0}}};
          beat_nxt_s     = ZERO_BEAT;
          inv_pend_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (mem_valid) begin
          beat_we_s = 1'b1;
          if (beat_r == LAST_BEAT) begin
            // Final beat: pending invalidate is consumed by the clear-all.
            fill_done_s    = 1'b1;
            state_nxt_s    = ST_IDLE;
            beat_nxt_s     = ZERO_BEAT;
            inv_pend_nxt_s = 1'b0;
          end else begin
            beat_nxt_s     = beat_r + ONE_BEAT;
            addr_nxt_s     = addr_r + 32'd4;
            inv_pend_nxt_s = inv_pend_r | inv;
          end
        end else begin
          inv_pend_nxt_s = inv_pend_r | inv;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        beat_nxt_s     = ZERO_BEAT;
        inv_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // An invalidate landing on the final beat itself counts as pending too.
  assign inv_all     = ((state_r == ST_IDLE) & inv) | (fill_done_s & (inv_pend_r | inv));
  assign fill_keep   = fill_done_s & ~(inv_pend_r | inv);
  assign fill_done   = fill_done_s;
  assign beat_we     = beat_we_s;
  assign beat        = beat_r;
  assign state       = state_r;
  assign inv_pending = inv_pend_r;
  assign line_base   = base_r;
  assign mem_req     = (state_r == ST_REFILL);
  assign mem_addr    = addr_r;

endmodule

// File: rtl/icache_fetch.sv
// -----------------------------------------------------------------------------
// icache_fetch
// Direct-mapped instruction cache between the fetch PC and instruction memory.
// A hit returns the instruction combinationally; a miss raises stall, refills
// one line beat by beat from memory and then re-evaluates the lookup.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   pc           fetch byte address (held by the pipeline while stall=1)
//   inv          one-cycle invalidate-all pulse
//   instr        instruction for IF/ID, NOP when not a hit
//   stall        freezes PC and IF/ID while high
//   mem_req      refill request, high for the whole refill
//   mem_addr     byte address of the beat currently requested
//   mem_rdata    returned word
//   mem_valid    one pulse per returned beat, in address order
// -----------------------------------------------------------------------------
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        inv,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int OB = off_bits(WORDS);
  localparam int IB = idx_bits(LINES);
  localparam int TW = tag_bits(LINES, WORDS);

  logic [OB-1:0] pc_off_s;
  logic [IB-1:0] pc_idx_s;
  logic [TW-1:0] pc_tag_s;

  logic [LINES-1:0] valid_r;
  logic [TW-1:0]    tag_r  [LINES];
  logic [31:0]      data_r [LINES*WORDS];

  fetch_state_t  state_s;
  logic [OB-1:0] beat_s;
  logic          beat_we_s, fill_done_s, fill_keep_s, inv_all_s, inv_pend_s;
  logic [31:0]   line_base_s;
  logic [IB-1:0] ref_idx_s;
  logic [TW-1:0] ref_tag_s;
  logic          hit_s, start_s;
  logic          unused_misc_s;

  assign pc_off_s = pc[OB+1:2];
  assign pc_idx_s = pc[OB+2 +: IB];
  assign pc_tag_s = pc[31 -: TW];

  // The line being refilled is identified entirely by its captured base.
  assign ref_idx_s = line_base_s[OB+2 +: IB];
  assign ref_tag_s = line_base_s[31 -: TW];

  assign unused_misc_s = ^{pc[1:0], inv_pend_s, line_base_s[OB+1:0]};

  // Lookups only count while idle, so no stale hit leaks out mid-refill.
  assign hit_s   = valid_r[pc_idx_s] & (tag_r[pc_idx_s] == pc_tag_s) & (state_s == ST_IDLE);
  assign start_s = (state_s == ST_IDLE) & ~hit_s;

  icache_refill_ctrl #(
    .WORDS (WORDS)
  ) u_refill_ctrl (
    .clk         (clk),
    .reset       (reset),
    .start       (start_s),
    .pc          (pc),
    .inv         (inv),
    .mem_valid   (mem_valid),
    .state       (state_s),
    .beat        (beat_s),
    .beat_we     (beat_we_s),
    .fill_done   (fill_done_s),
    .fill_keep   (fill_keep_s),
    .inv_all     (inv_all_s),
    .inv_pending (inv_pend_s),
    .line_base   (line_base_s),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr)
  );

  // Valid bits: invalidate-all beats both a new miss and a completed fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
    end else if (inv_all_s) begin
      valid_r <= {LINES{1'b0}};
    end else if (start_s) begin
      valid_r[pc_idx_s] <= 1'b0;
    end else if (fill_keep_s) begin
      valid_r[ref_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data storage; contents are qualified by valid_r, so no reset.
  always_ff @(posedge clk) begin
    if (beat_we_s) begin
      data_r[{ref_idx_s, beat_s}] <= mem_rdata;
    end
    if (fill_done_s) begin
      tag_r[ref_idx_s] <= ref_tag_s;
    end
  end

  // Instruction mux: NOP whenever the lookup does not hit.
  always_comb begin
    instr = NOP_INSTR;
    if (hit_s) begin
      instr = data_r[{pc_idx_s, pc_off_s}];
    end else begin
      instr = NOP_INSTR;
    end
  end

  assign stall = ~hit_s;

endmodule
